safety_island_ecc_scrubber: RTL and testbench
=============================================

Name: safety_island_ecc_scrubber

Overview:
Background scrubber for one ECC-protected SRAM bank of the safety island. It periodically reads each word in turn. When the SRAM wrapper reports a single-bit error, it writes the corrected data back. It counts corrected and uncorrectable errors for the ECC manager registers. It sits between the ECC manager (configuration and counters) and the bank wrapper's port mux, with core traffic always taking priority.

Parameters:
BankNumBytes, 32'h0001_0000, bank size in bytes; must be a power of two.
DataWidth, 32, data word width; the wrapper encodes and decodes ECC internally.
AddrWidth, $clog2(BankNumBytes/(DataWidth/8)) = 14, word-address width; derived, not overridable.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
scrub_interval_i  in  32  cycles between scrub reads; 0 disables scrubbing
cnt_clear_i  in  1  synchronous clear of both counters
intc_req_i  in  1  core request to this bank in the current cycle
intc_we_i  in  1  core request is a write
intc_addr_i  in  AddrWidth  core word address
scrub_req_o  out  1  scrubber bank request
scrub_we_o  out  1  scrubber write enable
scrub_addr_o  out  AddrWidth  scrubber word address
scrub_wdata_o  out  DataWidth  write-back data
bank_rdata_i  in  DataWidth  corrected read data; valid 1 cycle after request
bank_single_err_i  in  1  correctable error on the returned read
bank_multi_err_i  in  1  uncorrectable error on the returned read
fix_cnt_o  out  32  corrected-error count; saturating
uncorrectable_cnt_o  out  32  uncorrectable-error count; saturating
uncorrectable_o  out  1  one-cycle pulse per uncorrectable error

Behaviour:
- Reset values: all outputs 0; FSM in Idle; address pointer 0; interval counter 0.
- FSM states: Idle, Read, Check, Write.
- Idle:
  - The interval counter increments every cycle while scrub_interval_i != 0.
  - When counter >= scrub_interval_i-1: counter clears and the FSM goes to Read.
  - If scrub_interval_i == 0: counter is held at 0 and the FSM stays in Idle.
  - A change of scrub_interval_i takes effect immediately through the comparison.
- Read:
  - scrub_req_o = !intc_req_i (combinational); scrub_we_o = 0; scrub_addr_o = pointer.
  - If intc_req_i = 1, the FSM stalls in Read with no request issued.
  - Otherwise the request is issued and the FSM goes to Check next cycle.
- Check (bank_* inputs sampled this cycle):
  - multi_err: increment uncorrectable_cnt_o, pulse uncorrectable_o next cycle, no write-back, advance pointer, go to Idle.
  - single_err: register bank_rdata_i into scrub_wdata_o, increment fix_cnt_o, go to Write.
  - single_err and multi_err both set: treat as multi only.
  - No error: advance pointer, go to Idle.
- Write:
  - scrub_req_o = scrub_we_o = !intc_req_i.
  - Stalls while intc_req_i = 1.
  - After the write issues: advance pointer, go to Idle.
- Core-write hazard: the write-back is aborted (pointer advances, go to Idle, fix count kept) when both hold:
  - intc_req_i && intc_we_i && intc_addr_i == pointer;
  - the FSM is in Check or Write.
- Pointer: increments by 1 and wraps from 2^AddrWidth-1 to 0.
- Counters:
  - Saturate at 32'hFFFF_FFFF.
  - cnt_clear_i has priority over a same-cycle increment; the result is 0.
  - The uncorrectable_o pulse is unaffected by cnt_clear_i.
- The scrubber never holds the bank for more than one cycle per request, so core latency increases by 0 cycles.
- Reset mid-operation returns the FSM to Idle immediately with no request outstanding; the pointer restarts at 0.

Decomposition:
- safety_island_pkg gains:
  - scrub_state_e (Idle/Read/Check/Write, logic [1:0]);
  - ScrubDefaultInterval = 32'd1024, used by the ECC manager's reset value.
- AddrWidth is derived from SafetyIslandDefaultConfig.BankNumBytes.
- One sub-module, safety_island_sat_counter (32-bit increment, clear, saturate), is instantiated twice.

Test Plan:
1. Clean bank, interval=4: scrub_req_o rises every 6 cycles at addresses 0,1,2...; counters stay 0; no writes.
2. Inject single_err with rdata=32'hDEADBEEF at addr 5: next scrub of addr 5 produces a write with wdata 32'hDEADBEEF at addr 5; fix_cnt_o=1.
3. Inject multi_err at addr 7: no write; uncorrectable_cnt_o=1; uncorrectable_o high for exactly 1 cycle.
4. Hold intc_req_i=1 for 10 cycles during Read: scrub_req_o stays 0 for all 10, then the request issues in the first free cycle.
5. single_err at addr 3 plus a core write to addr 3 in the Write state: no scrub write; fix_cnt_o=1; the core data is preserved.
6. Force the pointer to 16383 with interval=1: after the next scrub, scrub_addr_o=0. Preload the counter at 32'hFFFF_FFFF then inject a fix: the counter stays at 32'hFFFF_FFFF. Assert cnt_clear_i: the counter reads 0.

Source files
------------

// File: rtl/safety_island_pkg.sv
// Shared types and constants for the safety island ECC scrubbing logic.
//   scrub_state_e             : scrubber FSM encoding
//   SafetyIslandDefaultConfig : bank geometry the scrubber derives its widths from
//   ScrubDefaultInterval      : reset value of the ECC manager's interval register
//   scrub_addr_width()        : word-address width for a bank of a given size
package safety_island_pkg;

  // Bank geometry; BankNumBytes must be a power of two.
  typedef struct packed {
    logic [31:0] BankNumBytes;
    logic [31:0] DataWidth;
  } safety_island_cfg_t;

  localparam safety_island_cfg_t SafetyIslandDefaultConfig = '{
    BankNumBytes: 32'h0001_0000,
    DataWidth:    32'd32
  };

  localparam logic [31:0] ScrubDefaultInterval = 32'd1024;

  localparam int unsigned ScrubCntWidth = 32;

  typedef enum logic [1:0] {
    ScrubIdle  = 2'd0,
    ScrubRead  = 2'd1,
    ScrubCheck = 2'd2,
    ScrubWrite = 2'd3
  } scrub_state_e;

  // Number of word-address bits needed to cover the bank.
  function automatic int unsigned scrub_addr_width(input int unsigned bank_bytes,
                                                   input int unsigned data_width);
    return $clog2(bank_bytes / (data_width / 32'd8));
  endfunction

endpackage

// File: rtl/safety_island_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i / rst_ni : clock, asynchronous active-low reset
//   clr_i          : clear to zero; wins over a same-cycle increment
//   inc_i          : increment by one unless already at all-ones
//   cnt_o          : registered count
module safety_island_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: clear first, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/safety_island_ecc_scrubber.sv
// Background ECC scrubber for one safety-island SRAM bank. Walks the bank one
// word at a time, writes back corrected data on single-bit errors and counts
// corrected/uncorrectable errors. Core traffic always wins the bank port.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   scrub_interval_i         : idle cycles between scrub reads (0 = disabled)
//   cnt_clear_i              : synchronous clear of both error counters
//   intc_req_i/we_i/addr_i   : core access to the bank this cycle
//   scrub_req_o/we_o         : scrubber bank request (combinational, yields to core)
//   scrub_addr_o             : current scrub word pointer
//   scrub_wdata_o            : corrected data to write back
//   bank_rdata_i             : corrected read data, one cycle after request
//   bank_single_err_i        : correctable error on the returned read
//   bank_multi_err_i         : uncorrectable error on the returned read
//   fix_cnt_o                : saturating corrected-error count
//   uncorrectable_cnt_o      : saturating uncorrectable-error count
//   uncorrectable_o          : one-cycle pulse per uncorrectable error
module safety_island_ecc_scrubber
  import safety_island_pkg::*;
#(
  parameter int unsigned   BankNumBytes = SafetyIslandDefaultConfig.BankNumBytes,
  parameter int unsigned   DataWidth    = SafetyIslandDefaultConfig.DataWidth,
  localparam int unsigned  AddrWidth    = scrub_addr_width(BankNumBytes, DataWidth)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [31:0]              scrub_interval_i,
  input  logic                     cnt_clear_i,
  input  logic                     intc_req_i,
  input  logic                     intc_we_i,
  input  logic [AddrWidth-1:0]     intc_addr_i,
  output logic                     scrub_req_o,
  output logic                     scrub_we_o,
  output logic [AddrWidth-1:0]     scrub_addr_o,
  output logic [DataWidth-1:0]     scrub_wdata_o,
  input  logic [DataWidth-1:0]     bank_rdata_i,
  input  logic                     bank_single_err_i,
  input  logic                     bank_multi_err_i,
  output logic [ScrubCntWidth-1:0] fix_cnt_o,
  output logic [ScrubCntWidth-1:0] uncorrectable_cnt_o,
  output logic                     uncorrectable_o
);

  scrub_state_e         state_q, state_d;
  logic [AddrWidth-1:0] ptr_q, ptr_d;
  logic [31:0]          ival_q, ival_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 unc_pulse_q, unc_pulse_d;
  logic                 fix_inc, unc_inc;
  logic                 core_wr_hit;

  // A core write to the word being scrubbed makes our corrected copy stale.
  assign core_wr_hit = intc_req_i && intc_we_i && (intc_addr_i == ptr_q);

  // Next-state and bank-request logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ival_d      = ival_q;
    wdata_d     = wdata_q;
    unc_pulse_d = 1'b0;
    fix_inc     = 1'b0;
    unc_inc     = 1'b0;
    scrub_req_o = 1'b0;
    scrub_we_o  = 1'b0;

    unique case (state_q)
      ScrubIdle: begin
        if (scrub_interval_i == 32'd0) begin
          ival_d = 32'd0;
        end else if (ival_q >= (scrub_interval_i - 32'd1)) begin
          ival_d  = 32'd0;
          state_d = ScrubRead;
        end else begin
          ival_d = ival_q + 32'd1;
        end
      end

      ScrubRead: begin
        scrub_req_o = !intc_req_i;
        if (!intc_req_i) begin
          state_d = ScrubCheck;
        end
      end

      // Read response arrives this cycle; a multi-bit error masks a single.
      ScrubCheck: begin
        if (bank_multi_err_i) begin
          unc_inc     = 1'b1;
          unc_pulse_d = 1'b1;
          ptr_d       = ptr_q + AddrWidth'(1);
          state_d     = ScrubIdle;
        end else if (bank_single_err_i) begin
          fix_inc = 1'b1;
          wdata_d = bank_rdata_i;
          if (core_wr_hit) begin
            ptr_d   = ptr_q + AddrWidth'(1);
            state_d = ScrubIdle;
          end else begin
            state_d = ScrubWrite;
          end
        end else begin
          ptr_d   = ptr_q + AddrWidth'(1);
          state_d = ScrubIdle;
        end
      end

      ScrubWrite: begin
        scrub_req_o = !intc_req_i;
        scrub_we_o  = !intc_req_i;
        if (core_wr_hit || !intc_req_i) begin
          ptr_d   = ptr_q + AddrWidth'(1);
          state_d = ScrubIdle;
        end
      end

      default: begin
        state_d = ScrubIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ScrubIdle;
      ptr_q       <= '0;
      ival_q      <= 32'd0;
      wdata_q     <= '0;
      unc_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ival_q      <= ival_d;
      wdata_q     <= wdata_d;
      unc_pulse_q <= unc_pulse_d;
    end
  end

  assign scrub_addr_o    = ptr_q;
  assign scrub_wdata_o   = wdata_q;
  assign uncorrectable_o = unc_pulse_q;

  safety_island_sat_counter #(
    .Width (ScrubCntWidth)
  ) u_fix_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clear_i),
    .inc_i  (fix_inc),
    .cnt_o  (fix_cnt_o)
  );

  safety_island_sat_counter #(
    .Width (ScrubCntWidth)
  ) u_unc_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clear_i),
    .inc_i  (unc_inc),
    .cnt_o  (uncorrectable_cnt_o)
  );

endmodule

// File: tb/tb_safety_island_ecc_scrubber.sv
// Directed self-checking bench for safety_island_ecc_scrubber with a small
// bank-wrapper model that returns read data/error flags one cycle after a read.
module tb_safety_island_ecc_scrubber;

  localparam int unsigned AW = 14;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [31:0]   scrub_interval_i;
  logic          cnt_clear_i;
  logic          intc_req_i;
  logic          intc_we_i;
  logic [AW-1:0] intc_addr_i;
  logic          scrub_req_o;
  logic          scrub_we_o;
  logic [AW-1:0] scrub_addr_o;
  logic [31:0]   scrub_wdata_o;
  logic [31:0]   bank_rdata_i;
  logic          bank_single_err_i;
  logic          bank_multi_err_i;
  logic [31:0]   fix_cnt_o;
  logic [31:0]   uncorrectable_cnt_o;
  logic          uncorrectable_o;

  // Standalone narrow counter for the saturation/clear-priority checks.
  logic          sat_clr;
  logic          sat_inc;
  logic [3:0]    sat_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  safety_island_ecc_scrubber dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .scrub_interval_i    (scrub_interval_i),
    .cnt_clear_i         (cnt_clear_i),
    .intc_req_i          (intc_req_i),
    .intc_we_i           (intc_we_i),
    .intc_addr_i         (intc_addr_i),
    .scrub_req_o         (scrub_req_o),
    .scrub_we_o          (scrub_we_o),
    .scrub_addr_o        (scrub_addr_o),
    .scrub_wdata_o       (scrub_wdata_o),
    .bank_rdata_i        (bank_rdata_i),
    .bank_single_err_i   (bank_single_err_i),
    .bank_multi_err_i    (bank_multi_err_i),
    .fix_cnt_o           (fix_cnt_o),
    .uncorrectable_cnt_o (uncorrectable_cnt_o),
    .uncorrectable_o     (uncorrectable_o)
  );

  safety_island_sat_counter #(.Width(4)) u_sat (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (sat_clr),
    .inc_i  (sat_inc),
    .cnt_o  (sat_cnt)
  );

  // Bank wrapper model with per-address error injection.
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          inj_single = 1'b0;
  logic [AW-1:0] inj_s_addr = '0;
  logic [31:0]   inj_data = '0;
  logic          inj_multi = 1'b0;
  logic [AW-1:0] inj_m_addr = '0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  int            unc_pulses = 0;

  always @(posedge clk_i) begin
    rd_pend <= scrub_req_o && !scrub_we_o;
    rd_addr <= scrub_addr_o;
    if (scrub_req_o && !scrub_we_o) rd_cnt <= rd_cnt + 1;
    if (scrub_req_o && scrub_we_o) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= scrub_addr_o;
      wr_data <= scrub_wdata_o;
    end
    if (uncorrectable_o) unc_pulses <= unc_pulses + 1;
  end

  assign bank_single_err_i = rd_pend && inj_single && (rd_addr == inj_s_addr);
  assign bank_multi_err_i  = rd_pend && inj_multi && (rd_addr == inj_m_addr);
  assign bank_rdata_i      = !rd_pend ? 32'h0 :
                             bank_single_err_i ? inj_data : {18'h0, rd_addr};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for the next scrub read request; report its address and latency.
  task automatic wait_read(input string tag, input int limit,
                           output logic [AW-1:0] addr, output int cycles);
    logic found = 1'b0;
    cycles = 0;
    addr   = '0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk_i);
      #2;
      if (scrub_req_o && !scrub_we_o) begin
        found  = 1'b1;
        cycles = i;
        addr   = scrub_addr_o;
        break;
      end
    end
    check({tag, " found"}, 64'(found), 64'(1));
  endtask

  // Wait for a scrub read request to a specific address.
  task automatic wait_read_addr(input string tag, input int limit, input logic [AW-1:0] target);
    logic found = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk_i);
      #2;
      if (scrub_req_o && !scrub_we_o && (scrub_addr_o == target)) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, " found"}, 64'(found), 64'(1));
  endtask

  logic [AW-1:0] a;
  int            n;
  int            base;

  initial begin
    rst_ni           = 1'b0;
    scrub_interval_i = 32'd0;
    cnt_clear_i      = 1'b0;
    intc_req_i       = 1'b0;
    intc_we_i        = 1'b0;
    intc_addr_i      = '0;
    sat_clr          = 1'b0;
    sat_inc          = 1'b0;

    // Reset values
    #1;
    check("rst req",   64'(scrub_req_o), 64'(0));
    check("rst we",    64'(scrub_we_o), 64'(0));
    check("rst addr",  64'(scrub_addr_o), 64'(0));
    check("rst wdata", 64'(scrub_wdata_o), 64'(0));
    check("rst fix",   64'(fix_cnt_o), 64'(0));
    check("rst unc",   64'(uncorrectable_cnt_o), 64'(0));
    check("rst pulse", 64'(uncorrectable_o), 64'(0));
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Interval 0 disables scrubbing
    repeat (20) @(posedge clk_i);
    #2;
    check("disabled no reads", 64'(rd_cnt), 64'(0));

    // Test 1: clean bank, interval 4 -> read every 6 cycles at 0,1,2
    scrub_interval_i = 32'd4;
    wait_read("t1 r0", 20, a, n);
    check("t1 first latency", 64'(n), 64'(4));
    check("t1 addr0", 64'(a), 64'(0));
    wait_read("t1 r1", 20, a, n);
    check("t1 period1", 64'(n), 64'(6));
    check("t1 addr1", 64'(a), 64'(1));
    wait_read("t1 r2", 20, a, n);
    check("t1 period2", 64'(n), 64'(6));
    check("t1 addr2", 64'(a), 64'(2));
    check("t1 fix", 64'(fix_cnt_o), 64'(0));
    check("t1 unc", 64'(uncorrectable_cnt_o), 64'(0));
    check("t1 no writes", 64'(wr_cnt), 64'(0));

    // Test 2: single error at addr 5 -> write-back of corrected data
    inj_s_addr = 14'd5;
    inj_data   = 32'hDEADBEEF;
    inj_single = 1'b1;
    wait_read_addr("t2 read5", 100, 14'd5);
    @(posedge clk_i); #2;
    check("t2 check no req", 64'(scrub_req_o), 64'(0));
    @(posedge clk_i); #2;
    check("t2 wr req",  64'(scrub_req_o), 64'(1));
    check("t2 wr we",   64'(scrub_we_o), 64'(1));
    check("t2 wr addr", 64'(scrub_addr_o), 64'(5));
    check("t2 wdata",   64'(scrub_wdata_o), 64'h0000_0000_DEAD_BEEF);
    check("t2 fix",     64'(fix_cnt_o), 64'(1));
    @(posedge clk_i); #2;
    check("t2 wr count", 64'(wr_cnt), 64'(1));
    check("t2 bank wr addr", 64'(wr_addr), 64'(5));
    check("t2 bank wr data", 64'(wr_data), 64'h0000_0000_DEAD_BEEF);
    check("t2 back to idle", 64'(scrub_req_o), 64'(0));
    inj_single = 1'b0;

    // Test 3: multi error at addr 7 -> count + single-cycle pulse, no write
    inj_m_addr = 14'd7;
    inj_multi  = 1'b1;
    wait_read_addr("t3 read7", 100, 14'd7);
    @(posedge clk_i); #2;
    check("t3 pulse before", 64'(uncorrectable_o), 64'(0));
    @(posedge clk_i); #2;
    check("t3 pulse high", 64'(uncorrectable_o), 64'(1));
    check("t3 unc cnt",    64'(uncorrectable_cnt_o), 64'(1));
    check("t3 no wr req",  64'(scrub_req_o), 64'(0));
    check("t3 ptr adv",    64'(scrub_addr_o), 64'(8));
    @(posedge clk_i); #2;
    check("t3 pulse after", 64'(uncorrectable_o), 64'(0));
    check("t3 wr count", 64'(wr_cnt), 64'(1));
    check("t3 pulse count", 64'(unc_pulses), 64'(1));
    check("t3 fix kept", 64'(fix_cnt_o), 64'(1));
    inj_multi = 1'b0;

    // Test 4: core holds the bank for 10 cycles while the scrubber is in Read
    wait_read_addr("t4 read8", 100, 14'd8);
    repeat (5) @(posedge clk_i);
    #1;
    intc_req_i  = 1'b1;
    intc_we_i   = 1'b0;
    intc_addr_i = 14'h1234;
    base        = rd_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #2;
      check($sformatf("t4 stall %0d", i), 64'(scrub_req_o), 64'(0));
    end
    check("t4 no reads while stalled", 64'(rd_cnt), 64'(base));
    check("t4 stalled addr", 64'(scrub_addr_o), 64'(9));
    #1 intc_req_i = 1'b0;
    #1;
    check("t4 first free req", 64'(scrub_req_o), 64'(1));
    check("t4 first free we",  64'(scrub_we_o), 64'(0));
    @(posedge clk_i); #2;
    check("t4 issued once", 64'(rd_cnt), 64'(base + 1));
    check("t4 check no req", 64'(scrub_req_o), 64'(0));

    // Counter clear
    #1 cnt_clear_i = 1'b1;
    @(posedge clk_i);
    #1 cnt_clear_i = 1'b0;
    #1;
    check("clr fix", 64'(fix_cnt_o), 64'(0));
    check("clr unc", 64'(uncorrectable_cnt_o), 64'(0));

    // Reset mid-operation: everything back to zero, pointer restarts
    wait_read("rst mid read", 20, a, n);
    check("rst mid addr before", 64'(a), 64'(10));
    #1 rst_ni = 1'b0;
    #1;
    check("rst mid req",   64'(scrub_req_o), 64'(0));
    check("rst mid addr",  64'(scrub_addr_o), 64'(0));
    check("rst mid wdata", 64'(scrub_wdata_o), 64'(0));
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    wait_read("rst mid restart", 20, a, n);
    check("rst mid restart addr", 64'(a), 64'(0));
    check("rst mid restart latency", 64'(n), 64'(4));

    // Test 5: single error at addr 3 with a core write to addr 3 during Write
    inj_s_addr = 14'd3;
    inj_data   = 32'h0BAD_F00D;
    inj_single = 1'b1;
    base       = wr_cnt;
    wait_read_addr("t5 read3", 100, 14'd3);
    @(posedge clk_i); #2;
    check("t5 check no req", 64'(scrub_req_o), 64'(0));
    @(posedge clk_i);
    #1;
    intc_req_i  = 1'b1;
    intc_we_i   = 1'b1;
    intc_addr_i = 14'd3;
    #1;
    check("t5 no scrub req", 64'(scrub_req_o), 64'(0));
    check("t5 no scrub we",  64'(scrub_we_o), 64'(0));
    check("t5 fix",          64'(fix_cnt_o), 64'(1));
    @(posedge clk_i);
    #1;
    intc_req_i = 1'b0;
    intc_we_i  = 1'b0;
    #1;
    check("t5 aborted idle", 64'(scrub_req_o), 64'(0));
    check("t5 ptr adv", 64'(scrub_addr_o), 64'(4));
    inj_single = 1'b0;
    wait_read("t5 next", 20, a, n);
    check("t5 next addr", 64'(a), 64'(4));
    check("t5 no scrub write", 64'(wr_cnt), 64'(base));
    check("t5 fix kept", 64'(fix_cnt_o), 64'(1));

    // Test 6: pointer wrap with interval 1
    scrub_interval_i = 32'd1;
    wait_read_addr("t6 read top", 60000, 14'd16383);
    wait_read("t6 wrap", 10, a, n);
    check("t6 wrap addr", 64'(a), 64'(0));
    check("t6 wrap period", 64'(n), 64'(3));
    scrub_interval_i = 32'd0;
    check("t6 fix", 64'(fix_cnt_o), 64'(1));
    check("t6 unc", 64'(uncorrectable_cnt_o), 64'(0));
    check("t6 no writes", 64'(wr_cnt), 64'(base));

    // Saturation and clear priority on the counter sub-module
    #1 sat_inc = 1'b1;
    repeat (15) @(posedge clk_i);
    #1;
    check("sat reach max", 64'(sat_cnt), 64'(15));
    repeat (3) @(posedge clk_i);
    #1;
    check("sat hold max", 64'(sat_cnt), 64'(15));
    sat_clr = 1'b1;
    @(posedge clk_i);
    #1;
    check("sat clr beats inc", 64'(sat_cnt), 64'(0));
    sat_clr = 1'b0;
    @(posedge clk_i);
    #1 sat_inc = 1'b0;
    check("sat inc after clr", 64'(sat_cnt), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
